// File: rtl/measure_result_fifo.sv
// Result capture FIFO with 96-to-32 bit serialiser on a valid/ready port.
// Optional drop counter enabled by defining MEASURE_RESULT_DROP_CNT_EN.
module measure_result_fifo #(
   parameter int unsigned DEPTH_LOG2 = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  reg_wr_en_i,
   input  logic [95:0]           reg_wr_data_i,
   input  logic                  clr_i,
   output logic                  rd_valid_o,
   input  logic                  rd_ready_i,
   output logic [31:0]           rd_data_o,
   output logic                  rd_last_o,
   output logic [DEPTH_LOG2:0]   fifo_level_o,
`ifdef MEASURE_RESULT_DROP_CNT_EN
   output logic [15:0]           drop_cnt_o,
`endif
   output logic                  ovf_o
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

   typedef enum logic [1:0] {
      IDLE,
      W0,
      W1,
      W2
   } state_t;

   logic [95:0]         mem [DEPTH];
   logic [DEPTH_LOG2:0] wr_ptr;
   logic [DEPTH_LOG2:0] rd_ptr;
   logic [95:0]         hold;
   logic [95:0]         head;
   state_t              state;
   logic                empty;
   logic                full;
   logic                hs;
   logic                pop;
   logic                push;
   logic                drop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                  (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
   assign fifo_level_o = wr_ptr - rd_ptr;
   assign head  = mem[rd_ptr[DEPTH_LOG2-1:0]];
   assign hs    = rd_valid_o & rd_ready_i;
   assign pop   = !clr_i && !empty &&
                  ((state == IDLE) || ((state == W2) && hs));
   assign push  = reg_wr_en_i && !clr_i && (!full || pop);
   assign drop  = reg_wr_en_i && !clr_i && !push;

   // Result storage; contents need no reset since pointers guard them.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr[DEPTH_LOG2-1:0]] <= reg_wr_data_i;
      end
   end

   // Circular buffer pointers; the extra MSB separates full from empty.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clr_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Sticky loss flag, cleared only by flush or reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ovf_o <= 1'b0;
      end else if (clr_i) begin
         ovf_o <= 1'b0;
      end else if (drop) begin
         ovf_o <= 1'b1;
      end
   end

`ifdef MEASURE_RESULT_DROP_CNT_EN
   // Saturating count of dropped results.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         drop_cnt_o <= '0;
      end else if (clr_i) begin
         drop_cnt_o <= '0;
      end else if (drop && (drop_cnt_o != 16'hFFFF)) begin
         drop_cnt_o <= drop_cnt_o + 16'd1;
      end
   end
`endif

   // Serialiser: hold register plus registered word/last/valid outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= IDLE;
         hold       <= '0;
         rd_valid_o <= 1'b0;
         rd_data_o  <= '0;
         rd_last_o  <= 1'b0;
      end else if (clr_i) begin
         state      <= IDLE;
         rd_valid_o <= 1'b0;
         rd_data_o  <= '0;
         rd_last_o  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (pop) begin
                  hold       <= head;
                  rd_data_o  <= head[31:0];
                  rd_valid_o <= 1'b1;
                  rd_last_o  <= 1'b0;
                  state      <= W0;
               end
            end
            W0: begin
               if (hs) begin
                  rd_data_o <= hold[63:32];
                  state     <= W1;
               end
            end
            W1: begin
               if (hs) begin
                  rd_data_o <= hold[95:64];
                  rd_last_o <= 1'b1;
                  state     <= W2;
               end
            end
            W2: begin
               if (hs) begin
                  if (pop) begin
                     hold       <= head;
                     rd_data_o  <= head[31:0];
                     rd_last_o  <= 1'b0;
                     state      <= W0;
                  end else begin
                     rd_valid_o <= 1'b0;
                     rd_data_o  <= '0;
                     rd_last_o  <= 1'b0;
                     state      <= IDLE;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/measure_result_fifo.md
Name: measure_result_fifo

Overview:
- Sits directly downstream of the measure block in the DFM datapath.
- Captures each 96-bit result pulse (reg_wr_en / reg_wr_data) into a small FIFO so that no completed gate window is lost while software or the bus side is busy.
- Serialises each result into three 32-bit words on a valid/ready read port, which feeds the AXI register or stream side.

Parameters:
- DEPTH_LOG2, default 2: FIFO depth is 2**DEPTH_LOG2 entries of 96 bits. Legal range is 1..6.

Ports:
- clk_i  input  1  system clock; all logic is on the rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- reg_wr_en_i  input  1  single-cycle strobe: a result is present on reg_wr_data_i.
- reg_wr_data_i  input  96  result word; fields are opaque to this block.
- clr_i  input  1  synchronous flush and clear of sticky status.
- rd_valid_o  output  1  rd_data_o holds a valid word.
- rd_ready_i  input  1  consumer accepts the word when rd_valid_o and rd_ready_i are both high.
- rd_data_o  output  32  current word of the current result.
- rd_last_o  output  1  high with the third (final) word of a result.
- fifo_level_o  output  DEPTH_LOG2+1  number of entries stored in the FIFO; excludes the holding register.
- ovf_o  output  1  sticky: a result was dropped because the FIFO was full.

Behaviour:
- Reset: while rst_n_i is low, all outputs are 0, FIFO pointers are 0, the FSM is in IDLE, and the holding register is 0. Reset takes effect immediately and mid-transfer data is discarded.
- Write rules:
  - A result is accepted on a clock edge when reg_wr_en_i=1, clr_i=0, and either level < DEPTH or a pop happens on the same edge.
  - Otherwise the result is dropped and ovf_o is set to 1 on that edge.
  - A simultaneous write and pop leaves the level unchanged.
- Storage: a circular buffer with wr_ptr/rd_ptr of DEPTH_LOG2+1 bits. Pointers wrap modulo 2**(DEPTH_LOG2+1). Full and empty are distinguished by the pointer MSB.
- Serialiser FSM: states IDLE, W0, W1, W2.
  - IDLE: if the FIFO is non-empty, pop the head into the 96-bit holding register and go to W0. rd_valid_o=0.
  - W0: rd_data_o = hold[31:0], rd_valid_o=1. Advance to W1 on handshake.
  - W1: rd_data_o = hold[63:32], rd_valid_o=1. Advance to W2 on handshake.
  - W2: rd_data_o = hold[95:64], rd_valid_o=1, rd_last_o=1. On handshake: if the FIFO is non-empty, pop the next result into hold and go to W0 with no bubble cycle; otherwise go to IDLE.
- rd_data_o, rd_last_o and rd_valid_o are registered outputs. Once rd_valid_o is high, they are held stable until the handshake.
- rd_ready_i may be high while rd_valid_o is low; this has no effect.
- Latency: with reg_wr_en_i high in cycle N and the block idle and empty, rd_valid_o rises in cycle N+2 with word0.
- Throughput: one word per cycle with rd_ready_i held at 1. Sustained capacity is one result per 3 cycles.
- Total buffering is DEPTH + 1 results (FIFO plus holding register).
- clr_i has priority over every other event. On the next edge:
  - the FIFO is empty and level=0;
  - the FSM is in IDLE, rd_valid_o=0 and rd_last_o=0;
  - ovf_o=0.
  - A write in the same cycle is discarded and not counted as an overflow.
- ovf_o clears only on clr_i or reset.

Optional Feature:
- Macro: MEASURE_RESULT_DROP_CNT_EN.
- Defined: adds output port drop_cnt_o [15:0]. It increments on every dropped result, saturates at 16'hFFFF, and is cleared by clr_i or reset.
- Undefined: the port and its counter are absent; ovf_o is the only loss indication. All other behaviour is identical in both builds.

Test Plan:
- Single result:
  - Stimulus: reg_wr_data_i = 96'h3333_3333_2222_2222_1111_1111 strobed in cycle N, rd_ready_i=1.
  - Response: rd_valid_o high in cycles N+2..N+4 with data 1111_1111, 2222_2222, 3333_3333; rd_last_o only in N+4; level returns to 0.
- Backpressure:
  - Stimulus: same single result, rd_ready_i=0 for 5 cycles, then 1.
  - Response: rd_valid_o=1 and rd_data_o=32'h1111_1111 stable for the whole stall; the three words then follow in order.
- Overflow (DEPTH_LOG2=2, rd_ready_i=0):
  - Stimulus: 6 consecutive strobes with values 1..6 in the low word.
  - Response: result 1 goes to hold; fifo_level_o=4; ovf_o=1 after the 6th strobe; drop_cnt_o=1 if the macro is defined.
- Drain:
  - Stimulus: continue from the overflow case with rd_ready_i=1.
  - Response: 15 consecutive valid cycles, low words 1..5 in order, no bubble between results, then rd_valid_o=0 and level=0; ovf_o stays 1.
- Flush:
  - Stimulus: clr_i pulsed while in W1 with 2 entries queued and a same-cycle reg_wr_en_i.
  - Response: next cycle rd_valid_o=0, fifo_level_o=0, ovf_o=0, and the concurrent write is lost.
- Reset mid-transfer:
  - Stimulus: rst_n_i driven low asynchronously between edges while in W2.
  - Response: all outputs 0 immediately. After release, a new strobe yields rd_valid_o two cycles later with word0.
